// File: rtl/multicycle_core.sv
// multicycle_core
//   Multi-cycle CPU core for a 16-bit instruction set (LW/SW/ADD/SUB/OR/AND/
//   SLT/ADDI/BEQ/JUMP/HALT). Each instruction walks FETCH -> DECODE -> EXEC
//   -> (MEM) -> WB. One shared instruction/data memory port is used for both
//   fetches and loads/stores.
//
// Ports
//   DCLK      in   clock, rising edge
//   RST_N     in   asynchronous active-low reset
//   MREQ      out  memory request valid
//   M_W       out  1 = write, 0 = read (valid while MREQ)
//   MADDR     out  memory address (valid while MREQ)
//   MDATAOUT  out  write data (valid while MREQ & M_W)
//   MDATAIN   in   read data, sampled on the edge where MREQ & MACK
//   MACK      in   memory acknowledge, completes the current request
//   PC_OUT    out  current program counter
//   STATE_OUT out  FSM state (0 FETCH,1 DECODE,2 EXEC,3 MEM,4 WB,7 HALT)
//   HALTED    out  high while in HALT
//   DBG_RADDR in   debug register read address
//   DBG_RDATA out  REG[DBG_RADDR], combinational; 0 for absent registers
//
// Memory handshake: a request is open from the cycle MREQ rises until the
// rising edge on which MREQ and MACK are both 1. MADDR, M_W and MDATAOUT do
// not change while the request is open. MREQ is low in the cycle after that
// edge, and MACK is ignored whenever MREQ is low. Every request state spends
// one cycle with MREQ low before raising it, which yields the idle cycle
// between requests and the 5-cycle (ALU) / 7-cycle (LW/SW) instruction time.

module multicycle_core #(
   parameter int                   WORD_SIZE = 16,
   parameter int                   ADDR_SIZE = 16,
   parameter int                   NUM_REGS  = 16,
   parameter logic [ADDR_SIZE-1:0] RESET_PC  = '0
) (
   input  logic                 DCLK,
   input  logic                 RST_N,
   output logic                 MREQ,
   output logic                 M_W,
   output logic [ADDR_SIZE-1:0] MADDR,
   output logic [WORD_SIZE-1:0] MDATAOUT,
   input  logic [WORD_SIZE-1:0] MDATAIN,
   input  logic                 MACK,
   output logic [ADDR_SIZE-1:0] PC_OUT,
   output logic [2:0]           STATE_OUT,
   output logic                 HALTED,
   input  logic [3:0]           DBG_RADDR,
   output logic [WORD_SIZE-1:0] DBG_RDATA
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd7
   } state_t;

   localparam logic [3:0] OP_LW   = 4'h0;
   localparam logic [3:0] OP_SW   = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_SLT  = 4'h6;
   localparam logic [3:0] OP_ADDI = 4'h7;
   localparam logic [3:0] OP_BEQ  = 4'h8;
   localparam logic [3:0] OP_JUMP = 4'h9;
   localparam logic [3:0] OP_HALT = 4'hF;

   state_t                 r_state;
   state_t                 w_next;
   logic [15:0]            r_ir;
   logic [ADDR_SIZE-1:0]   r_pc;
   logic [WORD_SIZE-1:0]   r_a;
   logic [WORD_SIZE-1:0]   r_b;
   logic [WORD_SIZE-1:0]   r_c;
   logic [WORD_SIZE-1:0]   r_res;
   logic                   r_mreq;
   logic                   r_mw;
   logic [ADDR_SIZE-1:0]   r_maddr;
   logic [WORD_SIZE-1:0]   r_mdataout;
   logic                   r_halted;
   logic [WORD_SIZE-1:0]   r_regs [NUM_REGS];

   logic [3:0]             w_op;
   logic [3:0]             w_r1;
   logic [3:0]             w_r2;
   logic [3:0]             w_r3;
   logic                   w_req_done;
   logic                   w_is_mem;
   logic                   w_wb_en;
   logic [WORD_SIZE-1:0]   w_alu;
   logic [ADDR_SIZE-1:0]   w_pc_inc;
   logic [ADDR_SIZE-1:0]   w_pc_next;
   logic [WORD_SIZE-1:0]   w_rf [16];

   assign w_op       = r_ir[15:12];
   assign w_r1       = r_ir[11:8];
   assign w_r2       = r_ir[7:4];
   assign w_r3       = r_ir[3:0];
   assign w_req_done = r_mreq & MACK;
   assign w_is_mem   = (w_op == OP_LW) || (w_op == OP_SW);
   assign w_wb_en    = (r_state == S_WB) &&
                       ((w_op == OP_LW) || ((w_op >= OP_ADD) && (w_op <= OP_ADDI)));

   // Full 16-entry read view; indices beyond NUM_REGS read as zero.
   for (genvar g = 0; g < 16; g++) begin : g_rf
      if (g < NUM_REGS) begin : g_real
         assign w_rf[g] = r_regs[g];
      end else begin : g_zero
         assign w_rf[g] = '0;
      end
   end

   // FSM state register
   always_ff @(posedge DCLK or negedge RST_N) begin
      if (!RST_N) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   // FSM next state
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:  if (w_req_done) w_next = S_DECODE;
         S_DECODE: w_next = S_EXEC;
         S_EXEC: begin
            if (w_is_mem)              w_next = S_MEM;
            else if (w_op == OP_HALT)  w_next = S_HALT;
            else                       w_next = S_WB;
         end
         S_MEM:    if (w_req_done) w_next = S_WB;
         S_WB:     w_next = S_FETCH;
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_FETCH;
      endcase
   end

   // ALU result, consumed at the end of EXEC
   always_comb begin
      w_alu = '0;
      case (w_op)
         OP_ADD:  w_alu = r_b + r_c;
         OP_SUB:  w_alu = r_b - r_c;
         OP_OR:   w_alu = r_b | r_c;
         OP_AND:  w_alu = r_b & r_c;
         OP_SLT:  w_alu = {{(WORD_SIZE-1){1'b0}}, (r_b < r_c)};
         OP_ADDI: w_alu = r_a + {{(WORD_SIZE-8){r_ir[7]}}, r_ir[7:0]};
         default: w_alu = '0;
      endcase
   end

   // Next PC, applied in WB
   always_comb begin
      w_pc_inc  = r_pc + {{(ADDR_SIZE-1){1'b0}}, 1'b1};
      w_pc_next = w_pc_inc;
      case (w_op)
         OP_BEQ:  if (r_a == r_b) w_pc_next = r_pc + {{(ADDR_SIZE-4){w_r3[3]}}, w_r3};
         OP_JUMP: w_pc_next = r_pc + {{(ADDR_SIZE-12){r_ir[11]}}, r_ir[11:0]};
         default: w_pc_next = w_pc_inc;
      endcase
   end

   // Datapath and memory-port registers
   always_ff @(posedge DCLK or negedge RST_N) begin
      if (!RST_N) begin
         r_pc       <= RESET_PC;
         r_ir       <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_c        <= '0;
         r_res      <= '0;
         r_mreq     <= 1'b0;
         r_mw       <= 1'b0;
         r_maddr    <= '0;
         r_mdataout <= '0;
         r_halted   <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (!r_mreq) begin
                  r_mreq  <= 1'b1;
                  r_mw    <= 1'b0;
                  r_maddr <= r_pc;
               end else if (MACK) begin
                  r_mreq <= 1'b0;
                  r_ir   <= MDATAIN[15:0];
               end
            end
            S_DECODE: begin
               r_a <= w_rf[w_r1];
               r_b <= w_rf[w_r2];
               r_c <= w_rf[w_r3];
            end
            S_EXEC: begin
               r_res <= w_alu;
               if (w_is_mem) r_maddr <= {{(ADDR_SIZE-8){1'b0}}, r_ir[7:0]};
               if (w_op == OP_SW) r_mdataout <= r_a;
               if (w_op == OP_HALT) r_halted <= 1'b1;
            end
            S_MEM: begin
               if (!r_mreq) begin
                  r_mreq <= 1'b1;
                  r_mw   <= (w_op == OP_SW);
               end else if (MACK) begin
                  r_mreq <= 1'b0;
                  r_mw   <= 1'b0;
                  if (w_op == OP_LW) r_res <= MDATAIN;
               end
            end
            S_WB:    r_pc <= w_pc_next;
            default: ;
         endcase
      end
   end

   // Register file; writes to absent registers are dropped
   always_ff @(posedge DCLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else if (w_wb_en) begin
         for (int i = 0; i < NUM_REGS; i++)
            if (w_r1 == 4'(i)) r_regs[i] <= r_res;
      end
   end

   assign MREQ      = r_mreq;
   assign M_W       = r_mw;
   assign MADDR     = r_maddr;
   assign MDATAOUT  = r_mdataout;
   assign PC_OUT    = r_pc;
   assign STATE_OUT = r_state;
   assign HALTED    = r_halted;
   assign DBG_RDATA = w_rf[DBG_RADDR];

endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core
//   Directed bench for multicycle_core. A memory responder answers requests
//   after a programmable delay (optionally with stray MACK pulses while idle).
//   An instruction-level model of the ISA produces the expected stream of
//   memory accesses, fetch spacing, final registers and PC; one compare
//   process checks every acknowledged access and the handshake each cycle.

module tb_multicycle_core;

   localparam int NR   = 12;
   localparam int HALF = 5;

   logic        DCLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        MREQ;
   logic        M_W;
   logic [15:0] MADDR;
   logic [15:0] MDATAOUT;
   logic [15:0] MDATAIN;
   logic        MACK;
   logic [15:0] PC_OUT;
   logic [2:0]  STATE_OUT;
   logic        HALTED;
   logic [3:0]  DBG_RADDR;
   logic [15:0] DBG_RDATA;

   always #HALF DCLK = ~DCLK;

   multicycle_core #(
      .WORD_SIZE(16), .ADDR_SIZE(16), .NUM_REGS(NR), .RESET_PC(16'h0000)
   ) dut (
      .DCLK(DCLK), .RST_N(RST_N), .MREQ(MREQ), .M_W(M_W), .MADDR(MADDR),
      .MDATAOUT(MDATAOUT), .MDATAIN(MDATAIN), .MACK(MACK), .PC_OUT(PC_OUT),
      .STATE_OUT(STATE_OUT), .HALTED(HALTED), .DBG_RADDR(DBG_RADDR),
      .DBG_RDATA(DBG_RDATA)
   );

   typedef struct packed {
      logic        fetch;
      logic        we;
      logic [15:0] addr;
      logic [15:0] data;
      logic [7:0]  gap;
   } acc_t;

   acc_t        exp_q[$];
   acc_t        cmp_e;
   logic [15:0] mem   [0:65535];
   logic [15:0] m_mem [0:65535];
   logic [15:0] m_regs [NR];
   logic [15:0] m_pc;
   logic [15:0] m_fetch_q[$];
   int          act_fetch_cyc[$];

   int tests = 0;
   int fails = 0;
   int ack_delay = 0;
   bit spur = 0;
   bit checking = 0;
   int cyc = 0;

   always @(posedge DCLK) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- memory responder ----------------
   int wait_cnt = 0;
   bit acked = 0;
   always @(negedge DCLK) begin
      if (MREQ && !acked) begin
         if (wait_cnt >= ack_delay) begin
            MACK    = 1'b1;
            MDATAIN = mem[MADDR];
            if (M_W) mem[MADDR] = MDATAOUT;
            acked   = 1'b1;
         end else begin
            MACK = 1'b0;
            wait_cnt++;
         end
      end else begin
         MACK = (spur && !MREQ) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (!MREQ) begin
            wait_cnt = 0;
            acked    = 1'b0;
         end
      end
   end

   // ---------------- compare process ----------------
   logic        p_mreq = 1'b0;
   logic        p_mack = 1'b0;
   logic        p_mw;
   logic [15:0] p_addr;
   logic [15:0] p_dout;
   always @(negedge DCLK) begin
      #1;
      if (checking) begin
         if (p_mreq && p_mack) begin
            check("mreq_drop_after_ack", 32'(MREQ), 32'd0);
         end else if (p_mreq && MREQ) begin
            check("hold_maddr", 32'(MADDR), 32'(p_addr));
            check("hold_mw", 32'(M_W), 32'(p_mw));
            check("hold_mdataout", 32'(MDATAOUT), 32'(p_dout));
         end
         if (HALTED) begin
            check("halt_mreq", 32'(MREQ), 32'd0);
            check("halt_state", 32'(STATE_OUT), 32'd7);
         end
         if (MREQ && MACK) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL extra_access: addr 0x%0h we %0b, expected no access", MADDR, M_W);
            end else begin
               cmp_e = exp_q.pop_front();
               check("acc_addr", 32'(MADDR), 32'(cmp_e.addr));
               check("acc_we", 32'(M_W), 32'(cmp_e.we));
               check("acc_data", M_W ? 32'(MDATAOUT) : 32'(MDATAIN), 32'(cmp_e.data));
               check("acc_state", 32'(STATE_OUT), cmp_e.fetch ? 32'd0 : 32'd3);
               if (cmp_e.fetch) begin
                  check("fetch_pc", 32'(PC_OUT), 32'(cmp_e.addr));
                  if (cmp_e.gap != 0)
                     check("fetch_gap", 32'(cyc - act_fetch_cyc[$]), 32'(cmp_e.gap));
                  act_fetch_cyc.push_back(cyc);
               end
            end
         end
         p_mreq = MREQ;
         p_mack = MACK;
         p_mw   = M_W;
         p_addr = MADDR;
         p_dout = MDATAOUT;
      end else begin
         p_mreq = 1'b0;
         p_mack = 1'b0;
      end
   end

   // ---------------- instruction-level model ----------------
   function automatic logic [15:0] m_rd(input logic [3:0] i);
      if (int'(i) >= NR) return 16'h0000;
      return m_regs[i];
   endfunction

   task automatic m_wr(input logic [3:0] i, input logic [15:0] v);
      if (int'(i) < NR) m_regs[i] = v;
   endtask

   task automatic model_run(input int d);
      logic [15:0] pc, nxt, ir, a, b, c, v, addr;
      logic [3:0]  op, r1, r2, r3;
      int          gap;
      bit          done;
      pc = 16'h0000;
      gap = 0;
      done = 0;
      for (int i = 0; i < NR; i++) m_regs[i] = 16'h0000;
      exp_q.delete();
      m_fetch_q.delete();
      for (int n = 0; n < 500 && !done; n++) begin
         ir = m_mem[pc];
         exp_q.push_back('{1'b1, 1'b0, pc, ir, 8'(gap)});
         m_fetch_q.push_back(pc);
         op = ir[15:12]; r1 = ir[11:8]; r2 = ir[7:4]; r3 = ir[3:0];
         a = m_rd(r1); b = m_rd(r2); c = m_rd(r3);
         addr = {8'h00, ir[7:0]};
         nxt = pc + 16'd1;
         gap = 5 + d;
         case (op)
            4'h0: begin
               v = m_mem[addr];
               exp_q.push_back('{1'b0, 1'b0, addr, v, 8'd0});
               m_wr(r1, v);
               gap = 7 + 2 * d;
            end
            4'h1: begin
               m_mem[addr] = a;
               exp_q.push_back('{1'b0, 1'b1, addr, a, 8'd0});
               gap = 7 + 2 * d;
            end
            4'h2: m_wr(r1, b + c);
            4'h3: m_wr(r1, b - c);
            4'h4: m_wr(r1, b | c);
            4'h5: m_wr(r1, b & c);
            4'h6: m_wr(r1, (b < c) ? 16'd1 : 16'd0);
            4'h7: m_wr(r1, a + {{8{ir[7]}}, ir[7:0]});
            4'h8: if (a == b) nxt = pc + {{12{r3[3]}}, r3};
            4'h9: nxt = pc + {{4{ir[11]}}, ir[11:0]};
            4'hF: begin
               done = 1;
               nxt = pc;
            end
            default: ;
         endcase
         pc = nxt;
      end
      m_pc = pc;
   endtask

   // ---------------- programs ----------------
   task automatic clear_mem();
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
   endtask

   task automatic load_prog_a();
      logic [15:0] p[16];
      p = '{16'h7105, 16'h72FD, 16'h2312, 16'h1140, 16'h0440, 16'h7601, 16'h3506, 16'h0750,
            16'h6876, 16'h6967, 16'h4A76, 16'h5B57, 16'h8163, 16'h7D07, 16'h20D1, 16'hF000};
      clear_mem();
      for (int i = 0; i < 16; i++) mem[i] = p[i];
      mem[16'h0050] = 16'h8000;
   endtask

   task automatic load_prog_b();
      clear_mem();
      mem[16'h0000] = 16'h7101;
      mem[16'h0001] = 16'h7202;
      mem[16'h0002] = 16'h9003;
      mem[16'h0003] = 16'h7363;
      mem[16'h0004] = 16'h9004;
      mem[16'h0005] = 16'hA000;
      mem[16'h0006] = 16'h811E;
      mem[16'h0008] = 16'h747F;
      mem[16'h0009] = 16'h9818;
      mem[16'hF821] = 16'h97FF;
      mem[16'h0020] = 16'h75FF;
      mem[16'h0021] = 16'hF000;
   endtask

   task automatic dbg_check(input int idx, input logic [15:0] exp, input string name);
      DBG_RADDR = 4'(idx);
      #1;
      check(name, 32'(DBG_RDATA), 32'(exp));
   endtask

   task automatic start_prog(input int d, input bit sp);
      RST_N = 1'b0;
      checking = 0;
      ack_delay = d;
      spur = sp;
      act_fetch_cyc.delete();
      for (int i = 0; i < 65536; i++) m_mem[i] = mem[i];
      model_run(d);
      repeat (2) @(negedge DCLK);
      RST_N = 1'b1;
      checking = 1;
   endtask

   task automatic run_prog(input int d, input bit sp, input int max_cyc);
      start_prog(d, sp);
      for (int i = 0; i < max_cyc && !HALTED; i++) @(negedge DCLK);
      #2;
      check("halt_reached", 32'(HALTED), 32'd1);
      repeat (4) @(negedge DCLK);
      #2;
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      check("pc_final", 32'(PC_OUT), 32'(m_pc));
      for (int i = 0; i < 16; i++) dbg_check(i, m_rd(4'(i)), $sformatf("reg%0d_vs_model", i));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [15:0] b_list[11];
      bit found;
      MACK = 1'b0;
      MDATAIN = 16'h0000;
      DBG_RADDR = 4'd0;
      RST_N = 1'b0;

      // reset state
      repeat (3) @(negedge DCLK);
      #1;
      check("rst_mreq", 32'(MREQ), 32'd0);
      check("rst_mw", 32'(M_W), 32'd0);
      check("rst_maddr", 32'(MADDR), 32'd0);
      check("rst_mdataout", 32'(MDATAOUT), 32'd0);
      check("rst_halted", 32'(HALTED), 32'd0);
      check("rst_pc", 32'(PC_OUT), 32'd0);
      check("rst_state", 32'(STATE_OUT), 32'd0);
      dbg_check(1, 16'h0000, "rst_r1");

      // program A: ALU ops, SW/LW, SLT/SUB corners, unequal BEQ, absent register
      load_prog_a();
      run_prog(0, 0, 3000);
      dbg_check(3, 16'h0002, "a_add_r3");
      dbg_check(4, 16'h0005, "a_lw_r4");
      dbg_check(5, 16'hFFFF, "a_sub_wrap_r5");
      dbg_check(7, 16'h8000, "a_lw_r7");
      dbg_check(8, 16'h0000, "a_slt_unsigned_r8");
      dbg_check(9, 16'h0001, "a_slt_r9");
      dbg_check(10, 16'h8001, "a_or_r10");
      dbg_check(11, 16'h8000, "a_and_r11");
      dbg_check(0, 16'h0005, "a_read_absent_r0");
      dbg_check(13, 16'h0000, "a_absent_r13");
      check("a_pc_halt", 32'(PC_OUT), 32'h000F);
      check("a_mem_0x40", 32'(mem[16'h0040]), 32'h0005);
      check("a_lat_alu", 32'(act_fetch_cyc[1] - act_fetch_cyc[0]), 32'd5);
      check("a_lat_sw", 32'(act_fetch_cyc[4] - act_fetch_cyc[3]), 32'd7);
      check("a_lat_lw", 32'(act_fetch_cyc[5] - act_fetch_cyc[4]), 32'd7);

      // HALT is sticky
      for (int i = 0; i < 20; i++) begin
         @(negedge DCLK);
         #2;
         check("halt_hold_mreq", 32'(MREQ), 32'd0);
         check("halt_hold_pc", 32'(PC_OUT), 32'h000F);
         check("halt_hold_flag", 32'(HALTED), 32'd1);
      end

      // program B: BEQ taken backwards, JUMP wrap, delayed MACK, stray MACK
      load_prog_b();
      b_list = '{16'h0000, 16'h0001, 16'h0002, 16'h0005, 16'h0006, 16'h0004,
                 16'h0008, 16'h0009, 16'hF821, 16'h0020, 16'h0021};
      run_prog(3, 1, 5000);
      check("b_model_fetch_count", 32'(m_fetch_q.size()), 32'd11);
      for (int i = 0; i < 11 && i < m_fetch_q.size(); i++)
         check($sformatf("b_model_fetch%0d", i), 32'(m_fetch_q[i]), 32'(b_list[i]));
      dbg_check(1, 16'h0001, "b_r1");
      dbg_check(3, 16'h0000, "b_skipped_r3");
      dbg_check(4, 16'h007F, "b_r4");
      dbg_check(5, 16'hFFFF, "b_r5");
      check("b_pc_halt", 32'(PC_OUT), 32'h0021);
      check("b_lat_delay3", 32'(act_fetch_cyc[1] - act_fetch_cyc[0]), 32'd8);

      // reset asserted while a fetch request is open
      start_prog(3, 0);
      found = 0;
      for (int i = 0; i < 500 && act_fetch_cyc.size() < 3; i++) @(negedge DCLK);
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge DCLK);
         #2;
         if (MREQ && !MACK && STATE_OUT == 3'd0) found = 1;
      end
      check("midrst_fetch_seen", 32'(found), 32'd1);
      checking = 0;
      RST_N = 1'b0;
      #1;
      check("midrst_mreq", 32'(MREQ), 32'd0);
      check("midrst_pc", 32'(PC_OUT), 32'd0);
      check("midrst_state", 32'(STATE_OUT), 32'd0);
      check("midrst_mw", 32'(M_W), 32'd0);
      dbg_check(1, 16'h0000, "midrst_r1");
      dbg_check(2, 16'h0000, "midrst_r2");
      run_prog(3, 0, 5000);
      check("midrst_rerun_pc", 32'(PC_OUT), 32'h0021);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
